wishbone_bus_splitter_reg: RTL and testbench

//   Registered 1-to-N Wishbone Classic splitter: next generation of the combinational splitter.

---
 rtl/wishbone_bus_splitter_reg.sv | 192 +++++++++++++++++++
 tb/tb_wishbone_bus_splitter_reg.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_bus_splitter_reg.sv
// rtl/wishbone_bus_splitter_reg.sv - registered 1-to-N Wishbone Classic splitter (optional watchdog: WB_SPLITTER_TIMEOUT_EN)
module wishbone_bus_splitter_reg #(
  parameter int NUM_PERIPHERALS  = 10,
  parameter int ADDR_WIDTH       = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int SEL_WIDTH        = DATA_WIDTH / 8,
  parameter int ADDR_SEL_LOW_BIT = 16,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hDEADBEEF),
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic                                  wb_clk_i,
  input  logic                                  wb_rst_ni,
  input  logic [ADDR_WIDTH-1:0]                 m_wb_adr_i,
  input  logic [DATA_WIDTH-1:0]                 m_wb_dat_i,
  output logic [DATA_WIDTH-1:0]                 m_wb_dat_o,
  input  logic                                  m_wb_we_i,
  input  logic [SEL_WIDTH-1:0]                  m_wb_sel_i,
  input  logic                                  m_wb_cyc_i,
  input  logic                                  m_wb_stb_i,
  output logic                                  m_wb_ack_o,
  output logic                                  m_wb_err_o,
  output logic [NUM_PERIPHERALS-1:0]            s_wb_cyc_o,
  output logic [NUM_PERIPHERALS-1:0]            s_wb_stb_o,
  output logic [NUM_PERIPHERALS-1:0]            s_wb_we_o,
  output logic [NUM_PERIPHERALS*SEL_WIDTH-1:0]  s_wb_sel_o,
  output logic [NUM_PERIPHERALS*ADDR_WIDTH-1:0] s_wb_adr_o,
  output logic [NUM_PERIPHERALS*DATA_WIDTH-1:0] s_wb_dat_o,
  input  logic [NUM_PERIPHERALS*DATA_WIDTH-1:0] s_wb_dat_i,
  input  logic [NUM_PERIPHERALS-1:0]            s_wb_ack_i,
  input  logic [NUM_PERIPHERALS-1:0]            s_wb_err_i,
  output logic                                  timeout_o
);

  localparam int N     = NUM_PERIPHERALS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
  logic                    we_q, we_d;
  logic [SEL_WIDTH-1:0]    sel_q, sel_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [N-1:0]            slv_en_q, slv_en_d;
  logic [DATA_WIDTH-1:0]   rdat_q, rdat_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic                    timeout_q, timeout_d;

  logic [IDX_W-1:0]        req_idx;
  logic                    req_hit;
  logic                    slv_ack;
  logic                    slv_err;
  logic                    to_hit;

  assign req_idx = m_wb_adr_i[ADDR_SEL_LOW_BIT +: IDX_W];
  assign req_hit = ({1'b0, req_idx} < (IDX_W + 1)'(N));
  assign slv_ack = s_wb_ack_i[idx_q];
  assign slv_err = s_wb_err_i[idx_q];

`ifdef WB_SPLITTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // watchdog counts BUSY cycles; it is zero on the first BUSY cycle
  always_comb begin
    cnt_d = '0;
    if (state_q == BUSY) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // watchdog counter register
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign to_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  // request capture, decode and response selection
  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    wdat_d    = wdat_q;
    we_d      = we_q;
    sel_d     = sel_q;
    idx_d     = idx_q;
    slv_en_d  = slv_en_q;
    rdat_d    = rdat_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (m_wb_cyc_i && m_wb_stb_i) begin
          adr_d  = m_wb_adr_i;
          wdat_d = m_wb_dat_i;
          we_d   = m_wb_we_i;
          sel_d  = m_wb_sel_i;
          idx_d  = req_idx;
          if (req_hit) begin
            slv_en_d = N'(1) << req_idx;
            state_d  = BUSY;
          end else begin
            err_d   = 1'b1;
            rdat_d  = ERR_DATA;
            state_d = RESP;
          end
        end
      end
      BUSY: begin
        if (!m_wb_cyc_i) begin
          // master abandoned the cycle: release the slave silently
          slv_en_d = '0;
          state_d  = IDLE;
        end else if (slv_err) begin
          err_d    = 1'b1;
          rdat_d   = ERR_DATA;
          slv_en_d = '0;
          state_d  = RESP;
        end else if (slv_ack) begin
          ack_d    = 1'b1;
          rdat_d   = s_wb_dat_i[idx_q*DATA_WIDTH +: DATA_WIDTH];
          slv_en_d = '0;
          state_d  = RESP;
        end else if (to_hit) begin
          err_d     = 1'b1;
          timeout_d = 1'b1;
          rdat_d    = ERR_DATA;
          slv_en_d  = '0;
          state_d   = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and datapath registers; reset clears every output
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q   <= IDLE;
      adr_q     <= '0;
      wdat_q    <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      idx_q     <= '0;
      slv_en_q  <= '0;
      rdat_q    <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      wdat_q    <= wdat_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      idx_q     <= idx_d;
      slv_en_q  <= slv_en_d;
      rdat_q    <= rdat_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  assign m_wb_dat_o = rdat_q;
  assign m_wb_ack_o = ack_q;
  assign m_wb_err_o = err_q;
  assign timeout_o  = timeout_q;
  assign s_wb_cyc_o = slv_en_q;
  assign s_wb_stb_o = slv_en_q;
  assign s_wb_we_o  = {N{we_q}};
  assign s_wb_sel_o = {N{sel_q}};
  assign s_wb_adr_o = {N{adr_q}};
  assign s_wb_dat_o = {N{wdat_q}};

endmodule

// File: tb/tb_wishbone_bus_splitter_reg.sv
// tb/tb_wishbone_bus_splitter_reg.sv - directed vector bench for wishbone_bus_splitter_reg
module tb_wishbone_bus_splitter_reg;

  localparam logic [95:0] SLV_RDATA = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
  localparam logic [31:0] DEAD      = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m_adr;
  logic [31:0] m_wdat;
  logic [31:0] m_rdat;
  logic        m_we;
  logic [3:0]  m_sel;
  logic        m_cyc;
  logic        m_stb;
  logic        m_ack;
  logic        m_err;
  logic [2:0]  s_cyc;
  logic [2:0]  s_stb;
  logic [2:0]  s_we;
  logic [11:0] s_sel;
  logic [95:0] s_adr;
  logic [95:0] s_wdat;
  logic [95:0] s_rdat;
  logic [2:0]  s_ack;
  logic [2:0]  s_err;
  logic        tmo;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] wdat;
    int          delay;
    logic [2:0]  ack_in;
    logic [2:0]  err_in;
    logic [2:0]  exp_stb;
    logic        exp_ack;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[8];

  wishbone_bus_splitter_reg #(
    .NUM_PERIPHERALS (3),
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .ADDR_SEL_LOW_BIT(16),
    .TIMEOUT_CYCLES  (8)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .m_wb_adr_i(m_adr),
    .m_wb_dat_i(m_wdat),
    .m_wb_dat_o(m_rdat),
    .m_wb_we_i (m_we),
    .m_wb_sel_i(m_sel),
    .m_wb_cyc_i(m_cyc),
    .m_wb_stb_i(m_stb),
    .m_wb_ack_o(m_ack),
    .m_wb_err_o(m_err),
    .s_wb_cyc_o(s_cyc),
    .s_wb_stb_o(s_stb),
    .s_wb_we_o (s_we),
    .s_wb_sel_o(s_sel),
    .s_wb_adr_o(s_adr),
    .s_wb_dat_o(s_wdat),
    .s_wb_dat_i(s_rdat),
    .s_wb_ack_i(s_ack),
    .s_wb_err_i(s_err),
    .timeout_o (tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    m_adr  = v.adr;
    m_we   = v.we;
    m_wdat = v.wdat;
    m_sel  = v.we ? 4'h3 : 4'hF;
    m_cyc  = 1'b1;
    m_stb  = 1'b1;
    tick();
    if (v.exp_stb == 3'b000) begin
      check({tag, ".miss_stb"}, s_stb, 3'b000);
      check({tag, ".miss_err"}, m_err, 1'b1);
      check({tag, ".miss_ack"}, m_ack, 1'b0);
      check({tag, ".miss_dat"}, m_rdat, DEAD);
    end else begin
      check({tag, ".stb"}, s_stb, v.exp_stb);
      check({tag, ".cyc"}, s_cyc, v.exp_stb);
      check({tag, ".adr"}, s_adr, {3{v.adr}});
      check({tag, ".wdat"}, s_wdat, {3{v.wdat}});
      check({tag, ".we"}, s_we, {3{v.we}});
      check({tag, ".sel"}, s_sel, {3{m_sel}});
      check({tag, ".early"}, {m_ack, m_err}, 2'b00);
      for (int i = 0; i < v.delay; i++) begin
        tick();
        check({tag, ".hold_stb"}, s_stb, v.exp_stb);
      end
      s_ack = v.ack_in;
      s_err = v.err_in;
      tick();
      s_ack = '0;
      s_err = '0;
      check({tag, ".ack"}, m_ack, v.exp_ack);
      check({tag, ".err"}, m_err, v.exp_err);
      check({tag, ".dat"}, m_rdat, v.exp_dat);
      check({tag, ".stb_clr"}, {s_stb, s_cyc}, 6'b0);
    end
    m_cyc = 1'b0;
    m_stb = 1'b0;
    tick();
    check({tag, ".pulse_end"}, {m_ack, m_err}, 2'b00);
    check({tag, ".dat_hold"}, m_rdat, v.exp_dat);
  endtask

  initial begin
    logic any_resp;
    logic stb_lost;

    vecs[0] = '{adr: 32'h0001_0004, we: 1'b1, wdat: 32'hA5A5_0001, delay: 1, ack_in: 3'b010, err_in: 3'b000,
                exp_stb: 3'b010, exp_ack: 1'b1, exp_err: 1'b0, exp_dat: 32'h2222_2222};
    vecs[1] = '{adr: 32'h0003_0000, we: 1'b0, wdat: 32'h0, delay: 0, ack_in: 3'b000, err_in: 3'b000,
                exp_stb: 3'b000, exp_ack: 1'b0, exp_err: 1'b1, exp_dat: DEAD};
    vecs[2] = '{adr: 32'h0002_0010, we: 1'b0, wdat: 32'h0, delay: 0, ack_in: 3'b101, err_in: 3'b100,
                exp_stb: 3'b100, exp_ack: 1'b0, exp_err: 1'b1, exp_dat: DEAD};
    vecs[3] = '{adr: 32'h0000_0020, we: 1'b0, wdat: 32'h0, delay: 2, ack_in: 3'b001, err_in: 3'b000,
                exp_stb: 3'b001, exp_ack: 1'b1, exp_err: 1'b0, exp_dat: 32'h1111_1111};
    vecs[4] = '{adr: 32'h0001_00F0, we: 1'b0, wdat: 32'h0, delay: 0, ack_in: 3'b010, err_in: 3'b001,
                exp_stb: 3'b010, exp_ack: 1'b1, exp_err: 1'b0, exp_dat: 32'h2222_2222};
    vecs[5] = '{adr: 32'h0001_0000, we: 1'b1, wdat: 32'h5A5A_1234, delay: 1, ack_in: 3'b000, err_in: 3'b010,
                exp_stb: 3'b010, exp_ack: 1'b0, exp_err: 1'b1, exp_dat: DEAD};
    vecs[6] = '{adr: 32'hFFFF_0000, we: 1'b0, wdat: 32'h0, delay: 0, ack_in: 3'b000, err_in: 3'b000,
                exp_stb: 3'b000, exp_ack: 1'b0, exp_err: 1'b1, exp_dat: DEAD};
    vecs[7] = '{adr: 32'h0004_0000, we: 1'b0, wdat: 32'h0, delay: 0, ack_in: 3'b001, err_in: 3'b000,
                exp_stb: 3'b001, exp_ack: 1'b1, exp_err: 1'b0, exp_dat: 32'h1111_1111};

    s_rdat = SLV_RDATA;
    s_ack  = '0;
    s_err  = '0;
    m_adr  = 32'h0001_0000;
    m_wdat = 32'hFFFF_FFFF;
    m_we   = 1'b1;
    m_sel  = 4'hF;
    m_cyc  = 1'b1;
    m_stb  = 1'b1;
    rst_n  = 1'b0;
    tick();
    tick();
    check("rst.m_out", {m_rdat, m_ack, m_err, tmo}, '0);
    check("rst.s_ctl", {s_cyc, s_stb, s_we, s_sel}, '0);
    check("rst.s_adr", s_adr, '0);
    check("rst.s_dat", s_wdat, '0);
    m_cyc = 1'b0;
    m_stb = 1'b0;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // back-to-back: STB held through the ack cycle starts a second transfer
    m_adr = 32'h0001_0008;
    m_we  = 1'b0;
    m_cyc = 1'b1;
    m_stb = 1'b1;
    tick();
    check("b2b.stb1", s_stb, 3'b010);
    s_ack = 3'b010;
    tick();
    s_ack = '0;
    check("b2b.ack1", m_ack, 1'b1);
    tick();
    check("b2b.idle", {s_stb, m_ack, m_err}, 5'b0);
    tick();
    check("b2b.stb2", s_stb, 3'b010);
    s_ack = 3'b010;
    tick();
    s_ack = '0;
    check("b2b.ack2", m_ack, 1'b1);
    m_cyc = 1'b0;
    m_stb = 1'b0;
    tick();

    // silent slave 0
    m_adr = 32'h0000_0000;
    m_cyc = 1'b1;
    m_stb = 1'b1;
    tick();
    check("to.stb", s_stb, 3'b001);
`ifdef WB_SPLITTER_TIMEOUT_EN
    any_resp = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      any_resp = any_resp | m_err | m_ack | tmo;
    end
    check("to.no_early", any_resp, 1'b0);
    tick();
    check("to.err", {m_err, tmo, m_ack}, 3'b110);
    check("to.dat", m_rdat, DEAD);
    check("to.stb_clr", s_stb, 3'b000);
    m_cyc = 1'b0;
    m_stb = 1'b0;
    tick();
    check("to.pulse_end", {m_err, tmo}, 2'b00);
`else
    any_resp = 1'b0;
    stb_lost = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      any_resp = any_resp | m_err | m_ack | tmo;
      stb_lost = stb_lost | (s_stb != 3'b001);
    end
    check("to.still_busy", {any_resp, stb_lost}, 2'b00);
    m_cyc = 1'b0;
    m_stb = 1'b0;
    tick();
    check("to.abort_clr", {s_stb, s_cyc, m_ack, m_err}, 8'b0);
`endif
    tick();

    // reset mid-BUSY
    m_adr  = 32'h0001_0040;
    m_wdat = 32'h1234_5678;
    m_we   = 1'b1;
    m_cyc  = 1'b1;
    m_stb  = 1'b1;
    tick();
    tick();
    check("rb.busy", s_stb, 3'b010);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_cyc = 1'b0;
    m_stb = 1'b0;
    check("rb.m_out", {m_rdat, m_ack, m_err, tmo}, '0);
    check("rb.s_ctl", {s_cyc, s_stb, s_we, s_sel}, '0);
    check("rb.s_adr", s_adr, '0);
    tick();
    run_vec(vecs[0], "rb.t1");

    // master abort mid-BUSY, late ack ignored, next read goes through
    m_adr = 32'h0002_0000;
    m_we  = 1'b0;
    m_cyc = 1'b1;
    m_stb = 1'b1;
    tick();
    tick();
    check("ab.busy", s_stb, 3'b100);
    m_cyc = 1'b0;
    m_stb = 1'b0;
    tick();
    check("ab.clr", {s_stb, s_cyc, m_ack, m_err}, 8'b0);
    s_ack = 3'b100;
    tick();
    s_ack = '0;
    check("ab.late_ack", {m_ack, m_err, s_stb}, 5'b0);
    vecs[0] = '{adr: 32'h0000_0000, we: 1'b0, wdat: 32'h0, delay: 0, ack_in: 3'b001, err_in: 3'b000,
                exp_stb: 3'b001, exp_ack: 1'b1, exp_err: 1'b0, exp_dat: 32'h1111_1111};
    run_vec(vecs[0], "ab.rd0");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
